riscv_mem_lsu: RTL and testbench

//  MEM-stage load/store unit: turns the EX/MEM register's MEM_ctrl + ALU address + rs2 data into one
//  OBI data-bus transaction (LW/SW, word only) and stalls the pipeline until the response returns.

---
 rtl/riscv_mem_lsu.sv | 66 ++++++
 tb/tb_riscv_mem_lsu.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_lsu.sv
// riscv_mem_lsu: MEM-stage word load/store unit driving one OBI transaction at a time, stalling until rvalid
module riscv_mem_lsu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mem_ctrl_i,
  input  logic [WIDTH-1:0]   addr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic               obi_req_o,
  input  logic               obi_gnt_i,
  output logic [WIDTH-1:0]   obi_addr_o,
  output logic               obi_we_o,
  output logic [WIDTH/8-1:0] obi_be_o,
  output logic [WIDTH-1:0]   obi_wdata_o,
  input  logic               obi_rvalid_i,
  input  logic [WIDTH-1:0]   obi_rdata_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               stall_o,
  output logic               misalign_o
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic             we_q;
  logic             requested, start, in_gnt, in_rv, load_done;
  // proc_req is active low: 0 means the EX/MEM register asks for an access
  assign requested  = (state_q == IDLE) && !mem_ctrl_i[1];
  assign start      = requested && (addr_i[1:0] == 2'b00);
  assign in_gnt     = (state_q == WAIT_GNT);
  assign in_rv      = (state_q == WAIT_RVALID);
  assign load_done  = in_rv && obi_rvalid_i && !we_q;
  assign misalign_o = requested && (addr_i[1:0] != 2'b00);
  assign obi_req_o  = start || in_gnt;
  assign obi_addr_o  = start ? addr_i : addr_q;
  assign obi_we_o    = start ? mem_ctrl_i[0] : we_q;
  assign obi_wdata_o = start ? wdata_i : wdata_q;
  assign obi_be_o   = '1;
  assign stall_o    = start || in_gnt || (in_rv && !obi_rvalid_i);
  assign rdata_o    = load_done ? obi_rdata_i : rdata_q;
  // Transaction FSM: latch the request on issue, hold it until grant, then wait for the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
          we_q    <= mem_ctrl_i[0];
          state_q <= obi_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
        WAIT_GNT: state_q <= obi_gnt_i ? WAIT_RVALID : WAIT_GNT;
        WAIT_RVALID: if (obi_rvalid_i) begin
          rdata_q <= load_done ? obi_rdata_i : rdata_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_mem_lsu.sv
// tb_riscv_mem_lsu: randomized self-checking bench acting as OBI slave with a transaction-level model
module tb_riscv_mem_lsu;
  localparam int W = 32;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [1:0]   mem_ctrl = 2'b10;
  logic [W-1:0] addr = '0, wdata = '0, rdata_in = '0;
  logic         gnt = 1'b0, rvalid = 1'b0;
  logic         obi_req_o, obi_we_o, stall_o, misalign_o;
  logic [W-1:0] obi_addr_o, obi_wdata_o, rdata_o;
  logic [W/8-1:0] obi_be_o;
  int           tests = 0, fails = 0;
  logic [W-1:0] exp_rdata = '0;

  riscv_mem_lsu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ctrl_i(mem_ctrl), .addr_i(addr), .wdata_i(wdata),
    .obi_req_o(obi_req_o), .obi_gnt_i(gnt), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(rvalid), .obi_rdata_i(rdata_in),
    .rdata_o(rdata_o), .stall_o(stall_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; mem_ctrl = 2'b10; gnt = 1'b0; rvalid = 1'b0;
    #2;
    tests++;
    if ({obi_req_o, stall_o, misalign_o, obi_we_o, obi_addr_o, obi_wdata_o, rdata_o, obi_be_o} !== {4'b0000, {3*W{1'b0}}, 4'hf}) begin
      fails++;
      $display("FAIL reset: req=%b stall=%b mis=%b we=%b addr=%h wdata=%h rdata=%h be=%h, want all zero be=f",
               obi_req_o, stall_o, misalign_o, obi_we_o, obi_addr_o, obi_wdata_o, rdata_o, obi_be_o);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_rdata = '0;
  endtask

  // One OBI transaction: bench grants after gd wait cycles and answers rd cycles after the grant cycle.
  task automatic test_transaction(input logic we, input logic [W-1:0] a, input logic [W-1:0] wd,
                                  input int gd, input int rd, input logic [W-1:0] rdv);
    @(negedge clk);
    mem_ctrl = {1'b0, we}; addr = a; wdata = wd; gnt = (gd == 0); rvalid = 1'b0;
    #1;
    tests++;
    if ({obi_req_o, stall_o, misalign_o, obi_addr_o, obi_we_o, obi_wdata_o, obi_be_o} !== {3'b110, a, we, wd, 4'hf}) begin
      fails++;
      $display("FAIL issue: req/stall/mis=%b%b%b addr=%h we=%b wdata=%h be=%h, want 110 addr=%h we=%b wdata=%h be=f",
               obi_req_o, stall_o, misalign_o, obi_addr_o, obi_we_o, obi_wdata_o, obi_be_o, a, we, wd);
    end
    for (int k = 1; k <= gd; k++) begin
      @(negedge clk);
      mem_ctrl = 2'($urandom); addr = W'($urandom); wdata = W'($urandom);
      gnt = (k == gd); rvalid = 1'($urandom);
      #1;
      tests++;
      if ({obi_req_o, stall_o, misalign_o, obi_addr_o, obi_we_o, obi_wdata_o} !== {3'b110, a, we, wd}) begin
        fails++;
        $display("FAIL wait_gnt[%0d]: req/stall/mis=%b%b%b addr=%h we=%b wdata=%h, want 110 addr=%h we=%b wdata=%h",
                 k, obi_req_o, stall_o, misalign_o, obi_addr_o, obi_we_o, obi_wdata_o, a, we, wd);
      end
    end
    for (int k = 0; k < rd; k++) begin
      @(negedge clk);
      mem_ctrl = 2'($urandom); addr = W'($urandom); wdata = W'($urandom);
      gnt = 1'($urandom); rvalid = 1'b0; rdata_in = W'($urandom);
      #1;
      tests++;
      if ({obi_req_o, stall_o, misalign_o, rdata_o} !== {3'b010, exp_rdata}) begin
        fails++;
        $display("FAIL wait_rvalid[%0d]: req/stall/mis=%b%b%b rdata=%h, want 010 rdata=%h",
                 k, obi_req_o, stall_o, misalign_o, rdata_o, exp_rdata);
      end
    end
    @(negedge clk);
    mem_ctrl = 2'($urandom); addr = W'($urandom); gnt = 1'($urandom); rvalid = 1'b1; rdata_in = rdv;
    if (!we) exp_rdata = rdv;
    #1;
    tests++;
    if ({obi_req_o, stall_o, misalign_o, rdata_o} !== {3'b000, exp_rdata}) begin
      fails++;
      $display("FAIL response: req/stall/mis=%b%b%b rdata=%h, want 000 rdata=%h",
               obi_req_o, stall_o, misalign_o, rdata_o, exp_rdata);
    end
  endtask

  task automatic test_idle_hold(input string name);
    @(negedge clk);
    mem_ctrl = 2'b10; gnt = 1'b0; rvalid = 1'b0; rdata_in = W'($urandom);
    #1;
    tests++;
    if ({obi_req_o, stall_o, misalign_o, rdata_o} !== {3'b000, exp_rdata}) begin
      fails++;
      $display("FAIL %s idle: req/stall/mis=%b%b%b rdata=%h, want 000 rdata=%h",
               name, obi_req_o, stall_o, misalign_o, rdata_o, exp_rdata);
    end
  endtask

  task automatic test_misalign();
    for (int off = 1; off < 4; off++) begin
      @(negedge clk);
      mem_ctrl = {1'b0, 1'($urandom)}; addr = 32'h100 | W'(off); wdata = W'($urandom); gnt = 1'b1;
      #1;
      tests++;
      if ({obi_req_o, stall_o, misalign_o, rdata_o} !== {3'b001, exp_rdata}) begin
        fails++;
        $display("FAIL misalign off=%0d: req/stall/mis=%b%b%b rdata=%h, want 001 rdata=%h",
                 off, obi_req_o, stall_o, misalign_o, rdata_o, exp_rdata);
      end
      test_idle_hold("misalign_pulse_end");
    end
  endtask

  task automatic test_spurious();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ctrl = 2'b10 | 2'($urandom); gnt = 1'($urandom); rvalid = 1'b1; rdata_in = W'($urandom);
      #1;
      tests++;
      if ({obi_req_o, stall_o, misalign_o, rdata_o} !== {3'b000, exp_rdata}) begin
        fails++;
        $display("FAIL spurious[%0d]: req/stall/mis=%b%b%b rdata=%h, want 000 rdata=%h",
                 k, obi_req_o, stall_o, misalign_o, rdata_o, exp_rdata);
      end
    end
    test_transaction(1'b0, 32'h80, '0, 0, 0, 32'h0BADF00D);
  endtask

  task automatic test_back_to_back();
    test_transaction(1'b0, 32'h10, '0, 0, 2, 32'hA5A55A5A);
    test_transaction(1'b1, 32'h14, 32'hFEEDFACE, 0, 2, 32'h11111111);
    test_idle_hold("back_to_back");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_ctrl = 2'b00; addr = 32'h40; wdata = '0; gnt = 1'b1; rvalid = 1'b0;
    @(negedge clk);
    mem_ctrl = 2'b10; gnt = 1'b0; rst_n = 1'b0; exp_rdata = '0;
    #1;
    tests++;
    if ({obi_req_o, stall_o, misalign_o, obi_we_o, obi_addr_o, obi_wdata_o, rdata_o} !== {4'b0000, {3*W{1'b0}}}) begin
      fails++;
      $display("FAIL reset_mid: req=%b stall=%b mis=%b we=%b addr=%h wdata=%h rdata=%h, want all zero",
               obi_req_o, stall_o, misalign_o, obi_we_o, obi_addr_o, obi_wdata_o, rdata_o);
    end
    @(negedge clk);
    rst_n = 1'b1; rvalid = 1'b1; rdata_in = 32'hCAFEF00D;
    #1;
    tests++;
    if ({obi_req_o, stall_o, rdata_o} !== {2'b00, exp_rdata}) begin
      fails++;
      $display("FAIL late_rvalid: req/stall=%b%b rdata=%h, want 00 rdata=%h", obi_req_o, stall_o, rdata_o, exp_rdata);
    end
    test_idle_hold("after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    for (int n = 0; n < 24; n++) begin
      a = W'($urandom) & ~W'(3);
      test_transaction(1'($urandom), a, W'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), W'($urandom));
    end
    test_idle_hold("random_end");
  endtask

  initial begin
    test_reset();
    test_transaction(1'b0, 32'h100, '0, 0, 0, 32'hDEADBEEF);
    test_idle_hold("lw_basic");
    test_transaction(1'b1, 32'h204, 32'h12345678, 3, 1, 32'h55555555);
    test_idle_hold("sw_slow_gnt");
    test_misalign();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
